// File: rtl/reg8_pkg.sv
// Shared types and helpers for the reg8 register-bank readout blocks.
package reg8_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } piso_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Zero-extension of narrower words leaves the XOR unchanged.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/reg8_piso_shift.sv
// Loadable shift register plus data-bit counter for the PISO reader.
module reg8_piso_shift #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             bit_out_o,
    output logic             bit_next_o,
    output logic             last_bit_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shift_d = din_i;
            cnt_d   = '0;
        end else if (shift_en_i) begin
            shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // bit_next is what reaches the output end after the next shift.
    assign bit_out_o  = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign bit_next_o = MSB_FIRST ? shift_q[WIDTH-2] : shift_q[1];
    assign last_bit_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/reg8_piso_reader.sv
// Framed serial readout of one parallel word: start, data, optional even parity, stop.
module reg8_piso_reader
    import reg8_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    piso_state_t state_q, state_d;
    logic        par_q, par_d;
    logic        load, shift_en;
    logic        bit_out, bit_next, last_bit;
    logic        sout_d, busy_d, ready_d, done_d;

    reg8_piso_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .shift_en_i (shift_en),
        .din_i      (din),
        .bit_out_o  (bit_out),
        .bit_next_o (bit_next),
        .last_bit_o (last_bit)
    );

    // Outputs are registered from next-state decode so they line up with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            par_q      <= 1'b0;
            sout       <= IDLE_LEVEL;
            busy       <= 1'b0;
            load_ready <= 1'b1;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            par_q      <= par_d;
            sout       <= sout_d;
            busy       <= busy_d;
            load_ready <= ready_d;
            done       <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        par_d    = par_q;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid && load_ready) begin
                    state_d = START;
                    load    = 1'b1;
                    par_d   = even_parity(64'(din));
                end
            end
            START:  if (bit_en) state_d = DATA;
            DATA: begin
                if (bit_en) begin
                    if (last_bit) state_d = PARITY_EN ? PARITY : STOP;
                    else          shift_en = 1'b1;
                end
            end
            PARITY: if (bit_en) state_d = STOP;
            STOP:   if (bit_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sout_d  = IDLE_LEVEL;
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        done_d  = (state_q == STOP) && (state_d == IDLE);
        case (state_d)
            START:  sout_d = ~IDLE_LEVEL;
            DATA:   sout_d = (state_q != DATA) ? bit_out : (shift_en ? bit_next : sout);
            PARITY: sout_d = par_q;
            default: sout_d = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_reg8_piso_reader.sv
// Directed bench for reg8_piso_reader: default config plus an LSB-first, no-parity instance.
module tb_reg8_piso_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_en0 = 1'b0, load_valid0 = 1'b0;
    logic [7:0] din0 = 8'h00;
    logic       load_ready0, sout0, busy0, done0;
    logic       bit_en1 = 1'b0, load_valid1 = 1'b0;
    logic [7:0] din1 = 8'h00;
    logic       load_ready1, sout1, busy1, done1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg8_piso_reader dut0 (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en0),
        .load_valid (load_valid0),
        .load_ready (load_ready0),
        .din        (din0),
        .sout       (sout0),
        .busy       (busy0),
        .done       (done0)
    );

    reg8_piso_reader #(
        .WIDTH      (8),
        .MSB_FIRST  (1'b0),
        .PARITY_EN  (1'b0),
        .IDLE_LEVEL (1'b1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en1),
        .load_valid (load_valid1),
        .load_ready (load_ready1),
        .din        (din1),
        .sout       (sout1),
        .busy       (busy1),
        .done       (done1)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Observed vectors are {sout, busy, done, load_ready}.
    task automatic test_reset();
        logic [3:0] exp = 4'b1001;
        for (int i = 0; i < 10; i++) begin
            din0 = 8'($urandom);
            din1 = 8'($urandom);
            load_valid0 = 1'($urandom_range(0, 1));
            load_valid1 = 1'($urandom_range(0, 1));
            bit_en0 = 1'($urandom_range(0, 1));
            bit_en1 = 1'($urandom_range(0, 1));
            cyc();
            total++;
            if ({sout0, busy0, done0, load_ready0} !== exp) begin
                bad++;
                $display("FAIL reset_dut0 i=%0d got=%b exp=%b", i, {sout0, busy0, done0, load_ready0}, exp);
            end
            total++;
            if ({sout1, busy1, done1, load_ready1} !== exp) begin
                bad++;
                $display("FAIL reset_dut1 i=%0d got=%b exp=%b", i, {sout1, busy1, done1, load_ready1}, exp);
            end
        end
        load_valid0 = 1'b0; load_valid1 = 1'b0;
        bit_en0 = 1'b0; bit_en1 = 1'b0;
        din0 = 8'h00; din1 = 8'h00;
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        logic [10:0] bits = 11'b0_10100101_0_1;
        logic [3:0]  exp;
        bit_en0 = 1'b1; din0 = 8'hA5; load_valid0 = 1'b1;
        cyc();
        load_valid0 = 1'b0; din0 = 8'h00;
        for (int c = 1; c <= 13; c++) begin
            if (c <= 11)      exp = {bits[11-c], 1'b1, 1'b0, 1'b0};
            else if (c == 12) exp = 4'b1011;
            else              exp = 4'b1001;
            total++;
            if ({sout0, busy0, done0, load_ready0} !== exp) begin
                bad++;
                $display("FAIL basic_a5 c=%0d got=%b exp=%b", c, {sout0, busy0, done0, load_ready0}, exp);
            end
            cyc();
        end
    endtask

    task automatic test_lsb_noparity();
        logic [9:0] bits = 10'b0_10000000_1;
        logic [3:0] exp;
        bit_en1 = 1'b1; din1 = 8'h01; load_valid1 = 1'b1;
        cyc();
        load_valid1 = 1'b0; din1 = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 10)      exp = {bits[10-c], 1'b1, 1'b0, 1'b0};
            else if (c == 11) exp = 4'b1011;
            else              exp = 4'b1001;
            total++;
            if ({sout1, busy1, done1, load_ready1} !== exp) begin
                bad++;
                $display("FAIL lsb_noparity c=%0d got=%b exp=%b", c, {sout1, busy1, done1, load_ready1}, exp);
            end
            cyc();
        end
        bit_en1 = 1'b0;
    endtask

    task automatic test_slow_bit_en();
        logic [10:0] bits = 11'b0_11111111_0_1;
        logic [3:0]  exp;
        for (int c = 0; c <= 46; c++) begin
            if (c >= 1) begin
                if (c <= 44)      exp = {bits[10-(c-1)/4], 1'b1, 1'b0, 1'b0};
                else if (c == 45) exp = 4'b1011;
                else              exp = 4'b1001;
                total++;
                if ({sout0, busy0, done0, load_ready0} !== exp) begin
                    bad++;
                    $display("FAIL slow_ff c=%0d got=%b exp=%b", c, {sout0, busy0, done0, load_ready0}, exp);
                end
            end
            bit_en0     = (c % 4 == 0) && (c <= 44);
            load_valid0 = (c == 0) || (c == 10);
            din0        = (c == 0) ? 8'hFF : 8'h00;
            cyc();
        end
        bit_en0 = 1'b0; load_valid0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits1 = 11'b0_00111100_0_1;
        logic [10:0] bits2 = 11'b0_11000011_0_1;
        logic [3:0]  exp;
        bit_en0 = 1'b1; din0 = 8'h3C; load_valid0 = 1'b1;
        cyc();
        for (int c = 1; c <= 25; c++) begin
            if (c <= 11)      exp = {bits1[11-c], 1'b1, 1'b0, 1'b0};
            else if (c == 12) exp = 4'b1011;
            else if (c <= 23) exp = {bits2[23-c], 1'b1, 1'b0, 1'b0};
            else if (c == 24) exp = 4'b1011;
            else              exp = 4'b1001;
            total++;
            if ({sout0, busy0, done0, load_ready0} !== exp) begin
                bad++;
                $display("FAIL back_to_back c=%0d got=%b exp=%b", c, {sout0, busy0, done0, load_ready0}, exp);
            end
            load_valid0 = (c <= 12);
            din0        = (c == 12) ? 8'hC3 : 8'h00;
            cyc();
        end
        load_valid0 = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [10:0] bits = 11'b0_01011010_0_1;
        logic [3:0]  exp;
        bit_en0 = 1'b1; din0 = 8'h5A; load_valid0 = 1'b1;
        cyc();
        load_valid0 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            exp = {bits[11-c], 1'b1, 1'b0, 1'b0};
            total++;
            if ({sout0, busy0, done0, load_ready0} !== exp) begin
                bad++;
                $display("FAIL midframe_pre c=%0d got=%b exp=%b", c, {sout0, busy0, done0, load_ready0}, exp);
            end
            if (c < 5) cyc();
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({sout0, busy0, done0, load_ready0} !== 4'b1001) begin
            bad++;
            $display("FAIL midframe_async got=%b exp=%b", {sout0, busy0, done0, load_ready0}, 4'b1001);
        end
        cyc();
        #3 rst = 1'b1;
        cyc();
        for (int c = 0; c < 4; c++) begin
            total++;
            if ({sout0, busy0, done0, load_ready0} !== 4'b1001) begin
                bad++;
                $display("FAIL midframe_nodone c=%0d got=%b exp=%b", c, {sout0, busy0, done0, load_ready0}, 4'b1001);
            end
            cyc();
        end
        din0 = 8'h5A; load_valid0 = 1'b1;
        cyc();
        load_valid0 = 1'b0; din0 = 8'h00;
        for (int c = 1; c <= 13; c++) begin
            if (c <= 11)      exp = {bits[11-c], 1'b1, 1'b0, 1'b0};
            else if (c == 12) exp = 4'b1011;
            else              exp = 4'b1001;
            total++;
            if ({sout0, busy0, done0, load_ready0} !== exp) begin
                bad++;
                $display("FAIL midframe_reload c=%0d got=%b exp=%b", c, {sout0, busy0, done0, load_ready0}, exp);
            end
            cyc();
        end
        bit_en0 = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        test_reset();
        test_basic();
        test_lsb_noparity();
        test_slow_bit_en();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
